// File: rtl/flash_pkg.sv
// Shared definitions for the flash burst fetch path: sequencer state encoding,
// flash address geometry and the command length decoding helper.
package flash_pkg;

    localparam int          FLASH_AW   = 24;
    localparam logic [23:0] FLASH_BASE = 24'h400000;
    localparam int          LEN_MAX    = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    // The 8-bit command length uses 0 to mean a full 256-byte burst.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'(LEN_MAX) : {1'b0, len};
    endfunction

endpackage

// File: rtl/flash_burst_fetch_if.sv
// Byte-reader request/response bus plus the buffered output stream of the
// burst fetcher; master is the fetcher side, slave is reader + consumer.
interface flash_burst_fetch_if #(
    parameter int AW    = 24,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic [7:0]    rd_data;

    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_take;
    logic [LW-1:0] level;

    modport master (
        output rd_req, rd_addr, out_valid, out_data, level,
        input  rd_ready, rd_data, out_take
    );

    modport slave (
        input  rd_req, rd_addr, out_valid, out_data, level,
        output rd_ready, rd_data, out_take
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an explicit occupancy counter;
// the head is shown combinationally and reads as zero while empty.
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_wr, do_rd;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign level = level_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_wr);
        rd_ptr_d = rd_ptr_q + PW'(do_rd);
        level_d  = level_q + LW'(do_wr) - LW'(do_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage has no reset; the pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/flash_burst_fetch.sv
// Burst-read sequencer: one outstanding byte read at a time into a FWFT FIFO.
// Define FLASH_BURST_ABORT_EN to add the abort input that cuts a burst short.
module flash_burst_fetch
    import flash_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int AW    = FLASH_AW,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW-1:0]       start_addr,
    input  logic [7:0]          len,
`ifdef FLASH_BURST_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                done,
    flash_burst_fetch_if.master bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [8:0]    rem_q, rem_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_req_q, rd_req_d;
    logic          stop_early;

    logic          fifo_wr;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    fifo_rdata;
    logic [LW-1:0] fifo_level;

`ifdef FLASH_BURST_ABORT_EN
    logic abort_pend_q, abort_pend_d;
    assign stop_early = abort_pend_q | abort;
`else
    assign stop_early = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through the case can infer a latch.
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_req_d  = 1'b0;
        fifo_wr   = 1'b0;
`ifdef FLASH_BURST_ABORT_EN
        abort_pend_d = abort_pend_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rd_addr_d = start_addr;
                    rem_d     = len_to_count(len);
                    busy_d    = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
`ifdef FLASH_BURST_ABORT_EN
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else
`endif
                // A free slot now stays free until the byte lands: only pops happen meanwhile.
                if (!fifo_full) begin
                    rd_req_d = 1'b1;
                    state_d  = ST_WAIT;
                end
            end

            ST_WAIT: begin
`ifdef FLASH_BURST_ABORT_EN
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
`endif
                if (bus.rd_ready) begin
                    fifo_wr   = 1'b1;
                    rd_addr_d = rd_addr_q + AW'(1);
                    rem_d     = rem_q - 9'd1;
                    if (stop_early || rem_q == 9'd1) begin
                        busy_d  = 1'b0;
                        done_d  = ~stop_early;
                        state_d = ST_IDLE;
`ifdef FLASH_BURST_ABORT_EN
                        abort_pend_d = 1'b0;
`endif
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge _d values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_req_q  <= 1'b0;
`ifdef FLASH_BURST_ABORT_EN
            abort_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_req_q  <= rd_req_d;
`ifdef FLASH_BURST_ABORT_EN
            abort_pend_q <= abort_pend_d;
`endif
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (fifo_wr),
        .wdata (bus.rd_data),
        .rd    (bus.out_take),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_data  = fifo_rdata;
    assign bus.level     = fifo_level;

endmodule

// File: tb/tb_flash_burst_fetch.sv
// Scoreboard bench for flash_burst_fetch: a reader model answers rd_req pulses,
// a monitor pops the FIFO and compares bytes against the queued expectations.
module tb_flash_burst_fetch;
    import flash_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [7:0]    len = '0;
    logic          busy;
    logic          done;
`ifdef FLASH_BURST_ABORT_EN
    logic          abort = 1'b0;
`endif

    always #5 clk = ~clk;

    flash_burst_fetch_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    flash_burst_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
`ifdef FLASH_BURST_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pattern(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h1A;
    endfunction

    logic [23:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];

    int   cyc = 0;
    int   rd_lat = 22;
    int   rd_cnt = 0;
    int   ready_cyc = -1;
    logic reader_busy = 1'b0;
    int   done_cnt = 0;
    int   take_mode = 0;   // 0 hold, 1 always, 2 toggle, 3 once on the next rd_ready cycle
    logic sim_pop_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Flash reader model: answers each pulse after rd_lat cycles with an address pattern.
    initial begin
        logic [23:0] a;
        bus.rd_ready = 1'b0;
        bus.rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && bus.rd_req === 1'b1) begin
                a = bus.rd_addr;
                rd_cnt++;
                if (exp_addr_q.size() == 0) check("rd_addr_extra_req", exp_addr_q.size(), 1);
                else                        check("rd_addr", a, exp_addr_q.pop_front());
                reader_busy = 1'b1;
                ready_cyc   = cyc + rd_lat;
                while (cyc < ready_cyc) @(negedge clk);
                bus.rd_ready = 1'b1;
                bus.rd_data  = pattern(a);
                @(negedge clk);
                bus.rd_ready = 1'b0;
                bus.rd_data  = 8'h00;
                reader_busy  = 1'b0;
            end
        end
    end

    // Consumer + scoreboard monitor.
    initial begin
        logic take;
        bus.out_take = 1'b0;
        forever begin
            @(negedge clk);
            take = 1'b0;
            case (take_mode)
                1: take = 1'b1;
                2: take = ~bus.out_take;
                3: if (cyc == ready_cyc) begin
                       take = 1'b1;
                       take_mode = 0;
                       sim_pop_done = 1'b1;
                   end
                default: take = 1'b0;
            endcase
            if (take && bus.out_valid === 1'b1) begin
                if (exp_data_q.size() == 0) check("out_extra_byte", exp_data_q.size(), 1);
                else                        check("out_data", bus.out_data, exp_data_q.pop_front());
            end
            bus.out_take = take;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    task automatic issue(input logic [23:0] a, input logic [7:0] l, input int n_exp);
        @(negedge clk);
        start = 1'b1;
        start_addr = a;
        len = l;
        for (int k = 0; k < n_exp; k++) begin
            exp_addr_q.push_back(a + 24'(k));
            exp_data_q.push_back(pattern(a + 24'(k)));
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int t;
        t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, done_cnt - d0, 1);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((bus.out_valid !== 1'b0 || exp_data_q.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_left"}, exp_data_q.size(), 0);
        check({name, "_valid"}, bus.out_valid, 0);
    endtask

    initial begin
        int d0, r0, t;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_req", bus.rd_req, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_level", bus.level, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte
        take_mode = 0; d0 = done_cnt; r0 = rd_cnt;
        issue(FLASH_BASE, 8'd1, 1);
        wait_done(d0, 200, "single_done");
        check("single_busy", busy, 0);
        check("single_valid", bus.out_valid, 1);
        check("single_data", bus.out_data, 8'h5A);
        check("single_level", bus.level, 1);
        check("single_reads", rd_cnt - r0, 1);
        take_mode = 1;
        wait_drain("single_drain");

        // Back-pressure: 40 bytes into a 16-entry FIFO with no pops
        take_mode = 0; d0 = done_cnt; r0 = rd_cnt;
        issue(FLASH_BASE + 24'h100, 8'd40, 40);
        t = 0;
        while (!((rd_cnt - r0) >= 16 && !reader_busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (60) @(negedge clk);
        check("bp_reads_stalled", rd_cnt - r0, 16);
        check("bp_busy", busy, 1);
        check("bp_level", bus.level, 16);
        check("bp_no_done", done_cnt - d0, 0);
        take_mode = 2;
        wait_done(d0, 3000, "bp_done");
        wait_drain("bp_drain");
        check("bp_reads_total", rd_cnt - r0, 40);
        check("bp_done_once", done_cnt - d0, 1);

        // Simultaneous write and pop at level 5, then a start while busy
        take_mode = 0; d0 = done_cnt; r0 = rd_cnt;
        issue(FLASH_BASE + 24'h200, 8'd8, 8);
        t = 0;
        while (bus.level !== 5'd5 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("simul_reach5", bus.level, 5);
        sim_pop_done = 1'b0;
        take_mode = 3;
        t = 0;
        while (!sim_pop_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("simul_pop_seen", sim_pop_done, 1);
        @(negedge clk);
        check("simul_level", bus.level, 5);
        issue(24'h123456, 8'd3, 0);
        check("busy_start_busy", busy, 1);
        wait_done(d0, 1000, "simul_done");
        check("simul_level_end", bus.level, 7);
        repeat (50) @(negedge clk);
        check("busy_start_reads", rd_cnt - r0, 8);
        check("busy_start_busy_end", busy, 0);
        take_mode = 1;
        wait_drain("simul_drain");

        // Address wrap
        take_mode = 1; d0 = done_cnt; r0 = rd_cnt;
        issue(24'hFFFFFE, 8'd4, 4);
        wait_done(d0, 500, "wrap_done");
        wait_drain("wrap_drain");
        check("wrap_reads", rd_cnt - r0, 4);

        // len = 0 means 256 bytes
        rd_lat = 4;
        take_mode = 1; d0 = done_cnt; r0 = rd_cnt;
        issue(FLASH_BASE + 24'h1000, 8'd0, 256);
        wait_done(d0, 5000, "len0_done");
        check("len0_reads_at_done", rd_cnt - r0, 256);
        wait_drain("len0_drain");
        rd_lat = 22;

        // Async reset in WAIT, then the late rd_ready must be ignored
        take_mode = 0; d0 = done_cnt; r0 = rd_cnt;
        issue(FLASH_BASE + 24'h300, 8'd5, 5);
        t = 0;
        while ((rd_cnt - r0) < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_rd_req", bus.rd_req, 0);
        check("arst_rd_addr", bus.rd_addr, 0);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data", bus.out_data, 0);
        check("arst_level", bus.level, 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t = 0;
        while (reader_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("late_ready_level", bus.level, 0);
        check("late_ready_valid", bus.out_valid, 0);
        check("late_ready_busy", busy, 0);
        check("late_ready_no_done", done_cnt - d0, 0);

`ifdef FLASH_BURST_ABORT_EN
        // Abort while a read is outstanding: keep that byte, no done pulse
        take_mode = 0; d0 = done_cnt; r0 = rd_cnt;
        issue(FLASH_BASE + 24'h400, 8'd10, 3);
        t = 0;
        while ((rd_cnt - r0) < 3 && t < 500) begin
            @(negedge clk);
            t++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        t = 0;
        while (reader_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_busy", busy, 0);
        check("abort_level", bus.level, 3);
        check("abort_reads", rd_cnt - r0, 3);
        take_mode = 1;
        wait_drain("abort_drain");
`endif

        check("leftover_addr", exp_addr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/flash_burst_fetch.md
Name: flash_burst_fetch

Overview:
- Burst-read sequencer between the QSPI flash byte reader and the UART transmit path.
- Accepts one command (start address, byte count) and issues single-byte read pulses to the flash reader, one outstanding at a time.
- Buffers returned bytes in a small FIFO; the UART/hex sender drains it with a valid/take handshake.
- Replaces the per-keystroke, one-byte-at-a-time control loop in the top level.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- AW, 24, flash address width.

Ports:
- clk  in  1  system clock (72 MHz PLL output)
- rst  in  1  reset
- start  in  1  one-cycle command strobe; ignored unless idle
- start_addr  in  AW  first byte address
- len  in  8  byte count; 0 encodes 256
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when last byte is written into the FIFO
- rd_req  out  1  one-cycle read pulse to flash reader
- rd_addr  out  AW  address presented with rd_req; held until rd_ready
- rd_ready  in  1  one-cycle pulse from reader; rd_data valid in the same cycle
- rd_data  in  8  byte from reader
- out_valid  out  1  FIFO non-empty
- out_data  out  8  FIFO head; valid while out_valid
- out_take  in  1  pop; ignored when out_valid=0
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high.
- Reset values: busy=0, done=0, rd_req=0, rd_addr=0, out_valid=0, out_data=0, level=0. The FIFO is emptied and the state goes to IDLE.
- States:
  - IDLE: on start, latch rd_addr<=start_addr and remaining<=(len==0 ? 256 : len) as a 9-bit count; set busy=1; go to ISSUE.
  - ISSUE: if level + 1 <= DEPTH (space for the outstanding byte), assert rd_req for exactly one cycle and go to WAIT. Otherwise hold in ISSUE with rd_req=0.
  - WAIT: on rd_ready, write rd_data into the FIFO, rd_addr<=rd_addr+1 (wraps modulo 2^AW; 0xFFFFFF→0x000000), remaining<=remaining-1.
    - If remaining was 1: done pulse, busy<=0, go to IDLE.
    - Otherwise go to ISSUE.
- Issue timing: the next rd_req is no earlier than the cycle after rd_ready, which guarantees the reader is back in IDLE.
- start while busy: ignored; no effect on the current burst.
- Throughput: one byte per reader transaction (~24 clk) plus 1 cycle of issue overhead.
- FIFO:
  - Synchronous write on the rd_ready accept; first-word-fall-through read.
  - out_data shows the head combinationally from registered pointers.
  - Write and pop in the same cycle: level is unchanged, and both operations occur.
  - Write when full cannot occur, because ISSUE gates it.
  - Pop when empty is ignored.
  - Pointers are log2(DEPTH) bits and wrap naturally. level is tracked as an explicit counter.
- FIFO contents persist after done until drained. A new command may start while the FIFO still holds data.
- rd_ready while in IDLE or ISSUE (spurious): ignored; no FIFO write.
- Reset mid-burst: everything clears immediately. The flash reader may still complete its transaction; its late rd_ready lands in IDLE and is ignored.

Optional Feature:
- Macro: FLASH_BURST_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort in ISSUE: go straight to IDLE with busy<=0 and no done pulse.
  - abort in WAIT: set a pending flag; on rd_ready, store the byte, then go to IDLE with no done pulse.
  - The FIFO is kept; abort in IDLE has no effect.
- Undefined: no abort port; bursts always run to completion.

Decomposition:
- Shared package flash_pkg:
  - state encoding typedef (IDLE, ISSUE, WAIT)
  - FLASH_AW=24
  - FLASH_BASE=24'h400000 (user data region)
  - LEN_MAX=256
- Sub-module sync_fifo (parameters DEPTH and WIDTH=8; ports wr, wdata, rd, rdata, empty, full, level) holds the buffer.
- The sequencer FSM stays in flash_burst_fetch.

Test Plan:
- Single byte: start with addr=0x400000, len=1, reader model returns 0x5A after 22 cycles → one rd_req at 0x400000, done pulse, out_valid=1, out_data=0x5A, busy=0.
- Back-pressure: len=40, DEPTH=16, out_take held 0 → exactly 16 rd_req, then stalls in ISSUE with busy=1.
  - Then toggle out_take continuously → remaining 24 bytes arrive in address order, one done pulse.
- Address wrap: start_addr=0xFFFFFE, len=4 → rd_addr sequence FFFFFE, FFFFFF, 000000, 000001.
- len=0 → 256 read pulses, data equal to an address-derived pattern, done after the 256th.
- Simultaneous push/pop with level=5 → level stays 5. A start while busy produces no change.
- Async reset asserted mid-WAIT → outputs zero without a clock edge. A subsequent late rd_ready writes nothing.
  - With FLASH_BURST_ABORT_EN: abort during WAIT on a len=10 burst → the pending byte is stored, no done pulse, busy=0.
